add_sequencer: RTL and testbench

ADD_SEQUENCER -- requirements
Module: add_sequencer

---
 rtl/add_sequencer_if.sv | 14 +
 rtl/add_sequencer.sv | 78 +++++++
 tb/tb_add_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/add_sequencer_if.sv
// add_sequencer_if: requester, result and external-adder signals of add_sequencer
interface add_sequencer_if #(parameter int NBYTES = 4);
  logic req0, req1, sub0, sub1, gnt0, gnt1, busy, done, owner, c, v, ad_ci, ad_c;
  logic [8*NBYTES-1:0] a0, b0, a1, b1, y;
  logic [7:0] ad_a, ad_b, ad_y;
  modport slave (
    input req0, req1, a0, b0, a1, b1, sub0, sub1, ad_y, ad_c,
    output gnt0, gnt1, busy, done, owner, y, c, v, ad_a, ad_b, ad_ci
  );
  modport master (
    output req0, req1, a0, b0, a1, b1, sub0, sub1, ad_y, ad_c,
    input gnt0, gnt1, busy, done, owner, y, c, v, ad_a, ad_b, ad_ci
  );
endinterface

// File: rtl/add_sequencer.sv
// add_sequencer: two-requester arbiter feeding a byte-serial add/subtract through an external 8-bit adder
module add_sequencer #(
  parameter int NBYTES = 4
) (
  input logic clk,
  input logic rst,
  add_sequencer_if.slave bus
);
  localparam int W = 8 * NBYTES;
  localparam int KW = $clog2(NBYTES);
  localparam logic [KW-1:0] KLAST = KW'(NBYTES - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] FIN = 2'd2;
  logic [1:0] state;
  logic [KW-1:0] k;
  logic [W-1:0] a_r, b_r, y_r;
  logic sub_r, last, owner_r, c_r, v_r, cy, just_rst, arb, grant;
  logic [7:0] ad_a, ad_b;
  logic ad_ci;
  // grants only from IDLE, never in the reset cycle or the one after; ties go to whoever was not served last
  always_comb begin
    arb = state == IDLE && !rst && !just_rst;
    bus.gnt0 = arb && bus.req0 && (!bus.req1 || last);
    bus.gnt1 = arb && bus.req1 && (!bus.req0 || !last);
    grant = bus.gnt0 || bus.gnt1;
    bus.busy = !rst && state != IDLE;
    bus.done = !rst && state == FIN;
  end
  // adder operands for byte k; B is inverted and carry-in seeded with 1 for subtraction
  always_comb begin
    ad_a = state == RUN ? a_r[8*k +: 8] : 8'd0;
    ad_b = state == RUN ? b_r[8*k +: 8] ^ {8{sub_r}} : 8'd0;
    ad_ci = state == RUN && (k == '0 ? sub_r : cy);
  end
  assign bus.ad_a = ad_a;
  assign bus.ad_b = ad_b;
  assign bus.ad_ci = ad_ci;
  assign bus.owner = owner_r;
  assign bus.y = y_r;
  assign bus.c = c_r;
  assign bus.v = v_r;
  // sequencer: latch winner's job, walk the bytes through the adder, flag completion
  always_ff @(posedge clk) begin
    just_rst <= rst;
    if (rst) begin
      state <= IDLE;
      k <= '0;
      last <= 1'b1;
      owner_r <= 1'b0;
      y_r <= '0;
      c_r <= 1'b0;
      v_r <= 1'b0;
      cy <= 1'b0;
    end else if (state == IDLE) begin
      if (grant) begin
        a_r <= bus.gnt1 ? bus.a1 : bus.a0;
        b_r <= bus.gnt1 ? bus.b1 : bus.b0;
        sub_r <= bus.gnt1 ? bus.sub1 : bus.sub0;
        owner_r <= bus.gnt1;
        last <= bus.gnt1;
        k <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      y_r[8*k +: 8] <= bus.ad_y;
      cy <= bus.ad_c;
      k <= k == KLAST ? '0 : k + 1'b1;
      if (k == KLAST) begin
        c_r <= bus.ad_c;
        v_r <= a_r[W-1] == (b_r[W-1] ^ sub_r) && bus.ad_y[7] != a_r[W-1];
        state <= FIN;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_add_sequencer.sv
// tb_add_sequencer: scoreboard bench for add_sequencer with a behavioural 8-bit adder
module tb_add_sequencer;
  typedef struct {
    logic [31:0] y;
    logic c, v, owner;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  exp_t sbq[$];
  bit to[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] ta[4] = '{32'h000000FF, 32'h7FFFFFFF, 32'h00000005, 32'hFFFFFFFF};
  logic [31:0] tbv[4] = '{32'h1, 32'h1, 32'h7, 32'h1};
  bit ts[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] ty[4] = '{32'h00000100, 32'h80000000, 32'hFFFFFFFE, 32'h0};
  bit tc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  bit tv[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  add_sequencer_if #(.NBYTES(4)) bus();
  add_sequencer #(.NBYTES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign {bus.ad_c, bus.ad_y} = 9'(bus.ad_a) + 9'(bus.ad_b) + 9'(bus.ad_ci);
  function automatic exp_t model(bit o, logic [31:0] a, logic [31:0] b, bit s);
    exp_t e;
    logic [31:0] bb;
    logic [32:0] r;
    bb = s ? ~b : b;
    r = {1'b0, a} + {1'b0, bb} + 33'(s);
    e.y = r[31:0];
    e.c = r[32];
    e.v = a[31] == bb[31] && r[31] != a[31];
    e.owner = o;
    return e;
  endfunction
  task automatic do_job(input bit o, input logic [31:0] a, input logic [31:0] b, input bit s,
                        output int tg, output int td);
    @(posedge clk); #1;
    if (o) begin bus.a1 = a; bus.b1 = b; bus.sub1 = s; bus.req1 = 1'b1; end
    else begin bus.a0 = a; bus.b0 = b; bus.sub0 = s; bus.req0 = 1'b1; end
    tg = -1;
    td = -1;
    for (int i = 0; i < 40 && td < 0; i++) begin
      @(negedge clk);
      if (tg < 0 && (o ? bus.gnt1 : bus.gnt0)) tg = cyc;
      if (bus.done) td = cyc;
      @(posedge clk); #1;
      if (tg >= 0) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    bus.req0 = 1'b1; bus.a0 = 32'h12; bus.b0 = 32'h34; bus.sub0 = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.gnt0, bus.gnt1, bus.busy, bus.done} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl got %b want 0000", {bus.gnt0, bus.gnt1, bus.busy, bus.done});
    end
    tests++;
    if ({bus.y, bus.c, bus.v, bus.owner} !== 35'd0) begin
      fails++; $display("FAIL reset_result got y=%h c=%b v=%b owner=%b want all 0", bus.y, bus.c, bus.v, bus.owner);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.gnt0, bus.busy, bus.done} !== 3'b000) begin
      fails++; $display("FAIL post_reset_quiet got %b want 000", {bus.gnt0, bus.busy, bus.done});
    end
    @(negedge clk);
    tests++;
    if (bus.gnt0 !== 1'b1) begin
      fails++; $display("FAIL first_grant got %b want 1", bus.gnt0);
    end
    @(posedge clk); #1 bus.req0 = 1'b0; rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      fails++; $display("FAIL reset_in_run got %b want 00", {bus.busy, bus.done});
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask
  task automatic test_arith;
    int tg, td;
    exp_t e;
    bit o, s;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        o = to[i]; a = ta[i]; b = tbv[i]; s = ts[i];
        e.y = ty[i]; e.c = tc[i]; e.v = tv[i]; e.owner = o;
      end else begin
        o = 1'($urandom_range(1)); a = $urandom; b = $urandom; s = 1'($urandom_range(1));
        e = model(o, a, b, s);
      end
      sbq.push_back(e);
      do_job(o, a, b, s, tg, td);
      tests++;
      if (tg < 0 || td - tg !== 5) begin
        fails++; $display("FAIL latency_%0d got grant=%0d done=%0d want done-grant=5", i, tg, td);
      end
      e = sbq.pop_front();
      tests++;
      if ({bus.y, bus.c, bus.v, bus.owner} !== {e.y, e.c, e.v, e.owner}) begin
        fails++; $display("FAIL result_%0d got y=%h c=%b v=%b o=%b want y=%h c=%b v=%b o=%b",
                          i, bus.y, bus.c, bus.v, bus.owner, e.y, e.c, e.v, e.owner);
      end
      @(negedge clk);
      tests++;
      if ({bus.done, bus.busy} !== 2'b00) begin
        fails++; $display("FAIL done_pulse_%0d got done/busy=%b want 00", i, {bus.done, bus.busy});
      end
    end
  endtask
  task automatic test_adder_bus;
    logic [31:0] a, b;
    logic [7:0] xa, xb;
    logic [8:0] r;
    logic ci;
    int ok;
    exp_t e;
    a = 32'h80FF00F0; b = 32'h01FF0F10;
    @(negedge clk);
    tests++;
    if ({bus.ad_a, bus.ad_b, bus.ad_ci} !== 17'd0) begin
      fails++; $display("FAIL adder_idle got %h want 0", {bus.ad_a, bus.ad_b, bus.ad_ci});
    end
    sbq.push_back(model(1'b0, a, b, 1'b1));
    @(posedge clk); #1;
    bus.a0 = a; bus.b0 = b; bus.sub0 = 1'b1; bus.req0 = 1'b1;
    ok = 0;
    for (int i = 0; i < 10 && ok == 0; i++) begin
      @(negedge clk);
      if (bus.gnt0) ok = 1;
    end
    tests++;
    if (ok == 0) begin fails++; $display("FAIL adder_grant got none want gnt0"); end
    @(posedge clk); #1;
    bus.req0 = 1'b0; bus.a0 = $urandom; bus.b0 = $urandom; bus.sub0 = 1'b0;
    ci = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      xa = a[8*k +: 8];
      xb = ~b[8*k +: 8];
      tests++;
      if ({bus.ad_a, bus.ad_b, bus.ad_ci} !== {xa, xb, ci}) begin
        fails++; $display("FAIL adder_byte%0d got a=%h b=%h ci=%b want a=%h b=%h ci=%b",
                          k, bus.ad_a, bus.ad_b, bus.ad_ci, xa, xb, ci);
      end
      r = 9'(xa) + 9'(xb) + 9'(ci);
      ci = r[8];
    end
    @(negedge clk);
    tests++;
    if ({bus.done, bus.ad_a, bus.ad_b, bus.ad_ci} !== {1'b1, 17'd0}) begin
      fails++; $display("FAIL adder_fin got done=%b bus=%h want done=1 bus=0", bus.done, {bus.ad_a, bus.ad_b, bus.ad_ci});
    end
    e = sbq.pop_front();
    tests++;
    if ({bus.y, bus.c, bus.v, bus.owner} !== {e.y, e.c, e.v, e.owner}) begin
      fails++; $display("FAIL adder_result got y=%h c=%b v=%b want y=%h c=%b v=%b", bus.y, bus.c, bus.v, e.y, e.c, e.v);
    end
  endtask
  task automatic test_back_to_back;
    int gc[3];
    bit go[3];
    int ng, nd, viol;
    exp_t e;
    ng = 0; nd = 0; viol = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.a0 = 32'h00001234; bus.b0 = 32'h00000234; bus.sub0 = 1'b1;
    bus.a1 = 32'hFFFF0000; bus.b1 = 32'h00010000; bus.sub1 = 1'b0;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    sbq.push_back(model(1'b0, 32'h00001234, 32'h00000234, 1'b1));
    sbq.push_back(model(1'b1, 32'hFFFF0000, 32'h00010000, 1'b0));
    sbq.push_back(model(1'b0, 32'h00001234, 32'h00000234, 1'b1));
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 40 && nd < 3; i++) begin
      @(negedge clk);
      if ((bus.gnt0 || bus.gnt1) && (bus.busy || (bus.gnt0 && bus.gnt1))) viol++;
      if (bus.gnt0 || bus.gnt1) begin
        if (ng < 3) begin gc[ng] = cyc; go[ng] = bus.gnt1; end
        ng++;
      end
      if (bus.done && sbq.size() > 0) begin
        e = sbq.pop_front();
        tests++;
        if ({bus.y, bus.c, bus.v, bus.owner} !== {e.y, e.c, e.v, e.owner}) begin
          fails++; $display("FAIL b2b_result%0d got y=%h o=%b want y=%h o=%b", nd, bus.y, bus.owner, e.y, e.owner);
        end
        nd++;
      end
      if (ng >= 3) begin @(posedge clk); #1 bus.req0 = 1'b0; bus.req1 = 1'b0; end
    end
    tests++;
    if (ng !== 3 || nd !== 3 || viol !== 0) begin
      fails++; $display("FAIL b2b_counts got grants=%0d dones=%0d viol=%0d want 3 3 0", ng, nd, viol);
    end
    tests++;
    if (ng >= 3 && ({go[0], go[1], go[2]} !== 3'b010 || gc[1] - gc[0] !== 6 || gc[2] - gc[1] !== 6)) begin
      fails++; $display("FAIL b2b_order got owners=%b gaps=%0d,%0d want 010 6,6",
                        {go[0], go[1], go[2]}, gc[1] - gc[0], gc[2] - gc[1]);
    end
  endtask
  task automatic test_midjob_reset;
    int ok, nd;
    exp_t e;
    @(posedge clk); #1;
    bus.a0 = 32'h0000FFFF; bus.b0 = 32'h00000001; bus.sub0 = 1'b0; bus.req0 = 1'b1;
    ok = 0;
    for (int i = 0; i < 10 && ok == 0; i++) begin
      @(negedge clk);
      if (bus.gnt0) ok = 1;
    end
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (ok == 0 || {bus.busy, bus.done, bus.gnt0, bus.y} !== 35'd0) begin
      fails++; $display("FAIL midreset_state got busy=%b done=%b gnt=%b y=%h want 0 0 0 0",
                        bus.busy, bus.done, bus.gnt0, bus.y);
    end
    sbq.push_back(model(1'b0, 32'h0000FFFF, 32'h00000001, 1'b0));
    ok = 0; nd = 0;
    for (int i = 0; i < 20 && nd == 0; i++) begin
      @(negedge clk);
      if (bus.gnt0) ok++;
      if (bus.done) begin
        nd = 1;
        e = sbq.pop_front();
        tests++;
        if ({bus.y, bus.c, bus.v, bus.owner} !== {e.y, e.c, e.v, e.owner}) begin
          fails++; $display("FAIL midreset_result got y=%h want %h", bus.y, e.y);
        end
      end
      @(posedge clk); #1;
      if (ok > 0) bus.req0 = 1'b0;
    end
    tests++;
    if (ok !== 1 || nd !== 1) begin
      fails++; $display("FAIL midreset_regrant got grants=%0d dones=%0d want 1 1", ok, nd);
    end
  endtask
  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.sub0 = 1'b0; bus.sub1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    test_reset();
    test_arith();
    test_adder_bus();
    test_back_to_back();
    test_midjob_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
